// File: rtl/riscv_pkg.sv
// Shared core constants: the architectural data width and the operand-source
// indices used by the forwarding muxes. The pipelined operand mux takes its
// defaults from here.
package riscv_pkg;

    // Architectural register width; default datapath width of the operand mux.
    localparam int XLEN = 32;

    // Operand-source indices as seen on the select of the operand mux.
    localparam int SRC_REG     = 0;
    localparam int SRC_MEM_FWD = 1;
    localparam int SRC_WB_FWD  = 2;

    // Number of operand sources; default input count of the operand mux.
    localparam int NUM_SRC = 3;

    // Width of a binary index able to address n inputs.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/operand_mux_pipe_if.sv
// Handshake bundle for operand_mux_pipe: the upstream valid/ready channel
// carrying the flattened candidates plus select, and the downstream
// valid/ready channel carrying the chosen operand and its select-error flag.
// master = the side that offers candidates and consumes results.
// slave  = operand_mux_pipe itself.
interface operand_mux_pipe_if
    import riscv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int NUM_IN = NUM_SRC
);
    localparam int SEL_W = sel_width(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_err;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_err
    );

endinterface

// File: rtl/operand_mux_comb.sv
// Purely combinational operand select. Candidate k sits at
// i_data[k*WIDTH +: WIDTH]; a select at or beyond NUM_IN falls back to
// candidate 0 so the pipeline always has a defined operand.
// Optional feature: OPERAND_MUX_SEL_CHECK_EN adds o_sel_err, high when the
// select is out of range.
module operand_mux_comb
    import riscv_pkg::*;
#(
    parameter  int WIDTH  = XLEN,
    parameter  int NUM_IN = NUM_SRC,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data
`ifdef OPERAND_MUX_SEL_CHECK_EN
    ,
    output logic                    o_sel_err
`endif
);

    // Select the indexed candidate; unmatched (out-of-range) selects keep candidate 0.
    always_comb begin
        // NOTE: the default assignment first covers every path, so no latch is inferred.
        o_data = i_data[0 +: WIDTH];
        for (int k = 1; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef OPERAND_MUX_SEL_CHECK_EN
    localparam logic [31:0] NUM_IN_U = 32'(NUM_IN);

    assign o_sel_err = (32'(i_sel) >= NUM_IN_U);
`endif

endmodule

// File: rtl/operand_mux_pipe.sv
// Registered operand mux with a valid/ready pipeline stage.
// Storage is an output register plus a single skid register (two beats).
// in_ready is a register equal to "skid register empty", so upstream never
// sees a combinational dependency on out_ready. With the output register
// draining every cycle the stage sustains one beat per cycle.
// Optional feature: OPERAND_MUX_SEL_CHECK_EN -- when defined, each beat carries
// an out-of-range-select flag to out_err; when undefined out_err is tied low.
module operand_mux_pipe
    import riscv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int NUM_IN = NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    operand_mux_pipe_if.slave  io_bus
);

    localparam int SEL_W = sel_width(NUM_IN);

    // Selected candidate for the beat offered this cycle.
    logic [WIDTH-1:0] w_sel_data;

    // Handshake decode.
    logic w_in_fire;    // beat accepted this cycle
    logic w_out_free;   // output register empty or draining this cycle
    logic w_skid_pop;   // stored skid beat moves into the output register
    logic w_out_load;   // accepted beat goes straight into the output register
    logic w_skid_load;  // accepted beat parks in the skid register

    // Pipeline state. r_in_ready doubles as the skid-empty flag.
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

`ifdef OPERAND_MUX_SEL_CHECK_EN
    logic w_sel_err;
    logic r_out_err;
    logic r_skid_err;
`endif

    operand_mux_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .i_data    (io_bus.in_data),
        .i_sel     (io_bus.in_sel),
        .o_data    (w_sel_data)
`ifdef OPERAND_MUX_SEL_CHECK_EN
        ,
        .o_sel_err (w_sel_err)
`endif
    );

    // A full skid register implies a full output register, so a pop only
    // happens when the output frees; in_ready low blocks new beats meanwhile.
    assign w_in_fire   = io_bus.in_valid & r_in_ready;
    assign w_out_free  = ~r_out_valid | io_bus.out_ready;
    assign w_skid_pop  = w_out_free & ~r_in_ready;
    assign w_out_load  = w_out_free & w_in_fire;
    assign w_skid_load = ~w_out_free & w_in_fire;

    // Occupancy control: output-valid and skid-empty (in_ready) flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flag see the pre-edge state of the others.
            if (w_out_free) begin
                r_out_valid <= w_skid_pop | w_in_fire;
            end
            if (w_skid_pop) begin
                r_in_ready <= 1'b1;
            end else if (w_skid_load) begin
                r_in_ready <= 1'b0;
            end
        end
    end

    // Output data register: refilled from the skid beat first, else from the mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_skid_pop) begin
            r_out_data <= r_skid_data;
        end else if (w_out_load) begin
            r_out_data <= w_sel_data;
        end
    end

    // Skid data register: captures a beat accepted while the output is stalled.
    // NOTE: no reset here; its contents are only ever read while r_in_ready marks it full.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_data <= w_sel_data;
        end
    end

`ifdef OPERAND_MUX_SEL_CHECK_EN
    // Output error flag follows the same load priority as the output data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_err <= 1'b0;
        end else if (w_skid_pop) begin
            r_out_err <= r_skid_err;
        end else if (w_out_load) begin
            r_out_err <= w_sel_err;
        end
    end

    // Skid error flag travels with the parked beat.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_err <= w_sel_err;
        end
    end

    assign io_bus.out_err = r_out_err;
`else
    assign io_bus.out_err = 1'b0;
`endif

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Self-checking bench for operand_mux_pipe: a directed vector table, hand
// sequences for back-pressure, streaming and asynchronous reset, a 64-bit
// five-input select sweep, and a randomized run against a two-entry FIFO model.
module tb_operand_mux_pipe;
    import riscv_pkg::*;

`ifdef OPERAND_MUX_SEL_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    operand_mux_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus_a ();
    operand_mux_pipe_if #(.WIDTH(64), .NUM_IN(5)) bus_b ();

    operand_mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_a)
    );

    operand_mux_pipe #(.WIDTH(64), .NUM_IN(5)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } beat_t;

    vec_t        vecs[6];
    logic [31:0] sw[16][3];
    logic [63:0] b_in[5];
    beat_t       q[$];
    beat_t       nb;
    logic [31:0] rd[3];
    logic [1:0]  rsel;
    logic        rv;
    logic        rr;
    logic        fin;
    logic        fout;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [1:0] sel, input logic vld, input logic rdy);
        bus_a.in_data   = {d2, d1, d0};
        bus_a.in_sel    = sel;
        bus_a.in_valid  = vld;
        bus_a.out_ready = rdy;
    endtask

    initial begin
        vecs[0] = '{32'h11, 32'h22, 32'h33, 2'd2, 32'h33, 1'b0};
        vecs[1] = '{32'h11, 32'h22, 32'h33, 2'd0, 32'h11, 1'b0};
        vecs[2] = '{32'h11, 32'h22, 32'h33, 2'd1, 32'h22, 1'b0};
        vecs[3] = '{32'h11, 32'h22, 32'h33, 2'd3, 32'h11, ERR_EN};
        vecs[4] = '{32'hAAAA5555, 32'hDEADBEEF, 32'h0BADF00D, 2'd1, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 32'h12345678, 2'd3, 32'hFFFFFFFF, ERR_EN};

        rst = 1'b1;
        drive_a(0, 0, 0, 0, 1'b0, 1'b0);
        bus_b.in_data   = '0;
        bus_b.in_sel    = '0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_a_out_valid", bus_a.out_valid, 0);
        check("rst_a_out_err",   bus_a.out_err,   0);
        check("rst_a_out_data",  bus_a.out_data,  0);
        check("rst_a_in_ready",  bus_a.in_ready,  1);
        check("rst_b_out_valid", bus_b.out_valid, 0);
        check("rst_b_in_ready",  bus_b.in_ready,  1);
        rst = 1'b0;

        // Directed vectors streamed back to back; first one lands on the first edge after reset.
        for (int i = 0; i < 6; i++) begin
            drive_a(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].sel, 1'b1, 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i),    bus_a.out_valid, 1);
            check($sformatf("vec%0d_data", i),     bus_a.out_data,  vecs[i].exp_data);
            check($sformatf("vec%0d_err", i),      bus_a.out_err,   vecs[i].exp_err);
            check($sformatf("vec%0d_in_ready", i), bus_a.in_ready,  1);
        end
        drive_a(0, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("vec_drain_valid", bus_a.out_valid, 0);

        // Back-pressure: A then B with out_ready low, then release.
        drive_a(32'hA0A0A0A0, 0, 0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_a_valid", bus_a.out_valid, 1);
        check("bp_a_data",  bus_a.out_data,  32'hA0A0A0A0);
        check("bp_a_ready", bus_a.in_ready,  1);
        drive_a(0, 32'hB0B0B0B0, 0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_full_ready", bus_a.in_ready,  0);
        check("bp_hold_data",  bus_a.out_data,  32'hA0A0A0A0);
        check("bp_hold_valid", bus_a.out_valid, 1);
        drive_a(32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_hold2_data",  bus_a.out_data, 32'hA0A0A0A0);
        check("bp_hold2_ready", bus_a.in_ready, 0);
        drive_a(0, 0, 0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("bp_b_valid", bus_a.out_valid, 1);
        check("bp_b_data",  bus_a.out_data,  32'hB0B0B0B0);
        check("bp_b_ready", bus_a.in_ready,  1);
        @(negedge clk);
        check("bp_empty_valid", bus_a.out_valid, 0);

        // Sixteen beats, one per cycle, no bubbles.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                for (int k = 0; k < 3; k++) sw[i][k] = $urandom;
                drive_a(sw[i][0], sw[i][1], sw[i][2], 2'(i % 3), 1'b1, 1'b1);
            end else begin
                drive_a(0, 0, 0, 2'd0, 1'b0, 1'b1);
            end
            @(negedge clk);
            if (i < 16) begin
                check($sformatf("stream%0d_valid", i), bus_a.out_valid, 1);
                check($sformatf("stream%0d_data", i),  bus_a.out_data,  sw[i][i % 3]);
            end
        end
        check("stream_end_valid", bus_a.out_valid, 0);

        // Asynchronous reset with two beats stored, then a fresh beat right after release.
        drive_a(32'h5A5A0001, 0, 0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive_a(0, 32'h5A5A0002, 0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        check("ar_full_ready", bus_a.in_ready,  0);
        check("ar_full_valid", bus_a.out_valid, 1);
        drive_a(0, 0, 0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_now_valid", bus_a.out_valid, 0);
        check("ar_now_ready", bus_a.in_ready,  1);
        check("ar_now_data",  bus_a.out_data,  0);
        check("ar_now_err",   bus_a.out_err,   0);
        @(negedge clk);
        drive_a(0, 0, 0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("ar_held_valid", bus_a.out_valid, 0);
        rst = 1'b0;
        drive_a(32'h77770000, 32'h77771111, 32'h77772222, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        check("ar_first_valid", bus_a.out_valid, 1);
        check("ar_first_data",  bus_a.out_data,  32'h77771111);
        drive_a(0, 0, 0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("ar_no_stale_valid", bus_a.out_valid, 0);

        // Five 64-bit inputs, select swept 0..7.
        for (int k = 0; k < 5; k++) b_in[k] = {$urandom, $urandom};
        bus_b.in_data   = {b_in[4], b_in[3], b_in[2], b_in[1], b_in[0]};
        bus_b.out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            bus_b.in_sel   = 3'(s);
            bus_b.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("b_sel%0d_valid", s), bus_b.out_valid, 1);
            check($sformatf("b_sel%0d_data", s),  bus_b.out_data,  (s < 5) ? b_in[s] : b_in[0]);
            check($sformatf("b_sel%0d_err", s),   bus_b.out_err,   ERR_EN && (s >= 5));
        end
        bus_b.in_valid = 1'b0;
        @(negedge clk);
        check("b_end_valid", bus_b.out_valid, 0);

        // Randomized traffic against a two-entry in-order queue model.
        for (int c = 0; c < 400; c++) begin
            check("rnd_out_valid", bus_a.out_valid, q.size() > 0);
            check("rnd_in_ready",  bus_a.in_ready,  q.size() < 2);
            if (q.size() > 0) begin
                check("rnd_out_data", bus_a.out_data, q[0].data);
                check("rnd_out_err",  bus_a.out_err,  q[0].err);
            end
            for (int k = 0; k < 3; k++) rd[k] = $urandom;
            rsel = 2'($urandom_range(0, 3));
            rv   = 1'($urandom_range(0, 1));
            rr   = ($urandom_range(0, 3) != 0);
            drive_a(rd[0], rd[1], rd[2], rsel, rv, rr);
            fin  = rv && (q.size() < 2);
            fout = (q.size() > 0) && rr;
            if (fout) void'(q.pop_front());
            if (fin) begin
                nb.data = (rsel < 3) ? rd[rsel] : rd[0];
                nb.err  = ERR_EN && (rsel == 2'd3);
                q.push_back(nb);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
